// File: rtl/serial_word_pkg.sv
// Shared types and constants for the serial word assembler.
package serial_word_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/word_out_buffer.sv
// One-entry valid/ready holding register for completed words, with sticky
// overflow when a word completes while the held word is not being taken.
module word_out_buffer
  import serial_word_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_word_i,
  input  logic             ready_i,
  input  logic             overflow_clr_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o,
  output logic             overflow_o
);

  buf_state_t       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      word_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state, held word and overflow; a completion in the handshake cycle passes through.
  always_comb begin
    logic ovf_set;
    state_d = state_q;
    word_d  = word_q;
    ovf_set = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (load_i) begin
          state_d = ST_FULL;
          word_d  = load_word_i;
        end
      end
      ST_FULL: begin
        if (load_i && ready_i) begin
          word_d = load_word_i;
        end else if (load_i) begin
          ovf_set = 1'b1;
        end else if (ready_i) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (overflow_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = (state_q == ST_FULL);
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Rebuilds WIDTH-bit words from a valid-qualified serial bit stream and hands
// them to a one-entry output buffer.
module serial_word_assembler
  import serial_word_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             busy_o,
  output logic             overflow_o,
  input  logic             overflow_clr_i
);

  localparam int unsigned     CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] pos_c;
  logic [WIDTH-1:0] word_full_c;
  logic             complete_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
    end
  end

  // Current word including this cycle's bit, so completion needs no extra cycle.
  always_comb begin
    pos_c              = MSB_FIRST ? (LAST_CNT - cnt_q) : cnt_q;
    word_full_c        = shreg_q;
    word_full_c[pos_c] = serial_i;
    complete_c         = valid_i && (cnt_q == LAST_CNT);
  end

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    if (valid_i) begin
      if (complete_c) begin
        cnt_d   = '0;
        shreg_d = '0;
        busy_d  = 1'b0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        shreg_d = word_full_c;
        busy_d  = 1'b1;
      end
    end
  end

  assign busy_o = busy_q;

  word_out_buffer #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk           (clk),
    .reset         (reset),
    .load_i        (complete_c),
    .load_word_i   (word_full_c),
    .ready_i       (word_ready_i),
    .overflow_clr_i(overflow_clr_i),
    .word_o        (word_o),
    .word_valid_o  (word_valid_o),
    .overflow_o    (overflow_o)
  );

endmodule

// File: tb/tb_serial_word_assembler.sv
// Drives an LSB-first and an MSB-first assembler with the same stream and
// compares both against a bit-queue reference model every cycle.
module tb_serial_word_assembler;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         serial_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         word_ready_i = 1'b0;
  logic         overflow_clr_i = 1'b0;
  logic [W-1:0] word0, word1;
  logic         wv0, wv1, busy0, busy1, ovf0, ovf1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: received bits of the partial word, and per-DUT buffer state.
  int       bitq[$];
  logic     m_full [2];
  int       m_word [2];
  logic     m_ovf  [2];

  always #5 clk = ~clk;

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i),
    .word_o(word0), .word_valid_o(wv0), .word_ready_i(word_ready_i),
    .busy_o(busy0), .overflow_o(ovf0), .overflow_clr_i(overflow_clr_i)
  );

  serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i),
    .word_o(word1), .word_valid_o(wv1), .word_ready_i(word_ready_i),
    .busy_o(busy1), .overflow_o(ovf1), .overflow_clr_i(overflow_clr_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bitq.delete();
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 1'b0;
      m_word[d] = 0;
      m_ovf[d]  = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs that were presented.
  task automatic model_step(input logic v, input logic b, input logic r, input logic c);
    int  words[2];
    bit  done;
    done = 1'b0;
    if (v) begin
      bitq.push_back(int'(b));
      if (bitq.size() == W) begin
        words[0] = 0;
        words[1] = 0;
        foreach (bitq[i]) begin
          words[0] += bitq[i] * (1 << i);
          words[1] = words[1] * 2 + bitq[i];
        end
        bitq.delete();
        done = 1'b1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (done && (!m_full[d] || r)) begin
        m_full[d] = 1'b1;
        m_word[d] = words[d];
        if (c) m_ovf[d] = 1'b0;
      end else if (done) begin
        m_ovf[d] = 1'b1;
      end else begin
        if (m_full[d] && r) m_full[d] = 1'b0;
        if (c) m_ovf[d] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic mbusy;
    mbusy = (bitq.size() != 0);
    check_eq("lsb_word",  32'(word0), 32'(m_word[0]));
    check_eq("lsb_valid", 32'(wv0),   32'(m_full[0]));
    check_eq("lsb_busy",  32'(busy0), 32'(mbusy));
    check_eq("lsb_ovf",   32'(ovf0),  32'(m_ovf[0]));
    check_eq("msb_word",  32'(word1), 32'(m_word[1]));
    check_eq("msb_valid", 32'(wv1),   32'(m_full[1]));
    check_eq("msb_busy",  32'(busy1), 32'(mbusy));
    check_eq("msb_ovf",   32'(ovf1),  32'(m_ovf[1]));
  endtask

  // One clock: present inputs, take the edge, update model, sample 1 time unit later.
  task automatic step(input logic v, input logic b, input logic r, input logic c);
    valid_i        = v;
    serial_i       = b;
    word_ready_i   = r;
    overflow_clr_i = c;
    @(posedge clk);
    model_step(v, b, r, c);
    #1;
    check_all();
  endtask

  // Send a nibble LSB first; ready is r_last on the final bit, r_other otherwise.
  task automatic send_nibble(input logic [3:0] val, input logic r_other, input logic r_last);
    for (int i = 0; i < 4; i++) step(1'b1, val[i], (i == 3) ? r_last : r_other, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    check_eq("rst_word_zero", 32'(word0 | word1), 32'd0);
    check_eq("rst_flags_zero", 32'({wv0, wv1, busy0, busy1, ovf0, ovf1}), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    check_eq("por_flags_zero", 32'({wv0, wv1, busy0, busy1, ovf0, ovf1}), 32'd0);
    reset = 1'b0;

    // Bits 1,0,1,1 back to back, consumer ready.
    send_nibble(4'b1101, 1'b1, 1'b1);
    check_eq("t1_lsb_D", 32'(word0), 32'hD);
    check_eq("t1_msb_B", 32'(word1), 32'hB);
    check_eq("t1_valid_rise", 32'(wv0), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t1_valid_one_cycle", 32'(wv0), 32'd0);

    // Bits 1,1,0,0 with three idle cycles between bits.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i < 2), 1'b0, 1'b0);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_busy_gap", 32'(busy0), 32'd1);
      end
    end
    check_eq("t3_lsb_3", 32'(word0), 32'h3);
    check_eq("t3_msb_C", 32'(word1), 32'hC);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow: 4'hA then 4'h5 with no consumer.
    send_nibble(4'hA, 1'b0, 1'b0);
    send_nibble(4'h5, 1'b0, 1'b0);
    check_eq("t4_lsb_hold_A", 32'(word0), 32'hA);
    check_eq("t4_ovf_set", 32'(ovf0), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t4_drained", 32'(wv0), 32'd0);
    check_eq("t4_ovf_sticky", 32'(ovf0), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t4_ovf_clr", 32'(ovf0), 32'd0);

    // Stream 1,2,3 with ready only on completion cycles: pass-through.
    send_nibble(4'h1, 1'b0, 1'b1);
    check_eq("t5_w1", 32'(word0), 32'h1);
    send_nibble(4'h2, 1'b0, 1'b1);
    check_eq("t5_w2", 32'(word0), 32'h2);
    send_nibble(4'h3, 1'b0, 1'b1);
    check_eq("t5_w3", 32'(word0), 32'h3);
    check_eq("t5_no_ovf", 32'(ovf0), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset after two bits of a word, then a clean 4'h6.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_nibble(4'h6, 1'b0, 1'b0);
    check_eq("t6_lsb_6", 32'(word0), 32'h6);
    check_eq("t6_msb_6", 32'(word1), 32'h6);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) < 65, 1'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 5);
      if ((n % 377) == 376) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
